reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Register-hazard scoreboard; the decode-side counterpart of the EX1→EX2→EX3→MEM→WB register chain.
- Decode issues destination writes into it and queries it for source operands.
- It tracks each in-flight write's pipeline age.
- It returns a decode stall plus per-operand forwarding selects naming which downstream stage (EX3, MEM, WB) holds the needed value.

Parameters:
NUM_REGS, 32, architectural registers tracked (register 0 never tracked)
AGE_W, 3, width of per-register age counter
ALU_READY_AGE, 2, age at which a non-load result is forwardable (EX3 output)
LOAD_READY_AGE, 4, age at which a load result is forwardable (WB)
RETIRE_AGE, 5, age at which the value is in the register file and the entry clears

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
issue_valid  in  1  decode presents an instruction this cycle
issue_regwrite  in  1  instruction writes a register
issue_is_load  in  1  instruction is a load (MemToReg)
issue_dst  in  5  destination register
flush  in  1  cancel the decode-stage instruction this cycle
q_rs, q_rt  in  5 each  source registers of the decode instruction
q_use_rs, q_use_rt  in  1 each  source actually read
stall  out  1  decode must hold
fwd_sel_rs, fwd_sel_rt  out  2 each  0=regfile, 1=EX3, 2=MEM, 3=WB
stall_cycles  out  32  stall counter (only with SCOREBOARD_STATS_EN)

Behaviour:
- Per-register state: busy, age[AGE_W-1:0], is_load. Register 0: busy forced 0.
- Reset: synchronous, active-high, checked first each edge.
  - All busy cleared, ages 0, is_load 0.
  - Outputs therefore: stall=0, fwd_sel_*=0, stall_cycles=0.
  - Reset mid-operation discards all in-flight entries.
- Query (combinational from current state, not from the same-cycle issue):
  - For source s with use=1 and busy[s]: ready = is_load ? age>=LOAD_READY_AGE : age>=ALU_READY_AGE.
  - stall = OR over the used sources of (busy & !ready).
  - fwd_sel by age when busy & ready: 2→1 (EX3), 3→2 (MEM), 4→3 (WB). Otherwise 0.
  - rs==rt: both get identical selects.
- Accept: accept = issue_valid & issue_regwrite & !stall & !flush & issue_dst!=0.
- On accept, next edge sets busy[dst]=1, age=0, is_load=issue_is_load.
  - This overwrites any older in-flight entry for dst (WAW: newest producer wins).
- Aging: every edge, each busy entry not being re-allocated does age+1.
  - When age+1 == RETIRE_AGE, the entry clears (busy=0).
  - Age never wraps: RETIRE_AGE < 2^AGE_W, enforced by a compile-time check.
- Retire and re-issue of the same register on the same edge: the re-issue wins (busy=1, age=0).
- Stall does not freeze aging: downstream stages keep advancing and bubbles are inserted.
- flush=1: no allocation this cycle; existing entries age normally.
- Latency: a consumer issued the cycle after an ALU producer stalls 2 cycles, then forwards from EX3.
  - Same case after a load producer: stalls 4 cycles, then forwards from WB.

Optional Feature:
- SCOREBOARD_STATS_EN defined:
  - stall_cycles increments each cycle stall=1 and issue_valid=1.
  - Saturates at 32'hFFFFFFFF; cleared by Reset.
- Not defined: stall_cycles tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd-select encoding constants FWD_RF=0, FWD_EX3=1, FWD_MEM=2, FWD_WB=3.
  - Default ready and retire ages.
  - REG_ADDR_W=5.
- Sub-module scoreboard_entry (one per register).
  - Holds busy/age/is_load and the aging, retire and allocate logic.
  - Outputs busy, ready, fwd code.
  - Top-level muxes entries by q_rs/q_rt and ORs the stall terms.

Test Plan:
1. Reset, then query q_rs=8, q_use_rs=1 → stall=0, fwd_sel_rs=0.
2. ALU producer to $8 (issue_is_load=0) at cycle 0, consumer reading $8 from cycle 1.
   - stall=1 at cycles 1–2.
   - Cycle 3: stall=0, fwd_sel_rs=1 (EX3).
   - Cycle 4: fwd_sel_rs=2.
   - Cycle 5: fwd_sel_rs=3.
   - Cycle ≥6: fwd_sel_rs=0.
3. Load to $9 at cycle 0, consumer on rt=$9 → stall=1 cycles 1–4; cycle 5 stall=0, fwd_sel_rt=3.
4. WAW: load to $10 at cycle 0, then ALU to $10 at cycle 1.
   - Consumer at cycle 3 (age 1 of the newer entry) → stall=1.
   - Cycle 4 → fwd_sel=1.
5. Flush with issue_valid=1, dst=$11 → no allocation; the next query of $11 gives stall=0.
   - Also: issue to $0 → never busy.
6. Reset asserted at cycle 2 of case 3 → the next cycle gives stall=0 and fwd_sel=0.
   - With SCOREBOARD_STATS_EN, stall_cycles=0 after reset and equals the stalled-cycle count otherwise (e.g., 4 after case 3).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the decode-side register scoreboard.
//   - REG_ADDR_W: width of an architectural register index.
//   - FWD_*: forwarding select encoding returned to decode.
//   - DEF_*_AGE: default ready/retire ages of an in-flight write.
//   - AGE_EX3/AGE_MEM/AGE_WB: age of a producer while it sits in each
//     forwarding stage (age 0 = EX1, 1 = EX2, 2 = EX3, 3 = MEM, 4 = WB).
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX3 = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int DEF_ALU_READY_AGE  = 2;
  localparam int DEF_LOAD_READY_AGE = 4;
  localparam int DEF_RETIRE_AGE     = 5;

  localparam int AGE_EX3 = 2;
  localparam int AGE_MEM = 3;
  localparam int AGE_WB  = 4;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode <-> scoreboard bundle.
//   master: decode side (drives issue/query fields, reads stall/selects).
//   slave : scoreboard side.
// Handshake: the issue fields are meaningful only while issue_valid=1. An
// instruction with issue_regwrite=1 is accepted on the rising edge where
// issue_valid=1, stall=0, flush=0 and issue_dst!=0; while stall=1 decode
// must hold the same instruction. stall and fwd_sel_* are combinational
// answers to the q_* fields presented in the same cycle.
// stall_cycles is only live when SCOREBOARD_STATS_EN is defined.
interface reg_scoreboard_if;
  import pipe_pkg::*;

  logic                  issue_valid;
  logic                  issue_regwrite;
  logic                  issue_is_load;
  logic [REG_ADDR_W-1:0] issue_dst;
  logic                  flush;
  logic [REG_ADDR_W-1:0] q_rs;
  logic [REG_ADDR_W-1:0] q_rt;
  logic                  q_use_rs;
  logic                  q_use_rt;
  logic                  stall;
  logic [1:0]            fwd_sel_rs;
  logic [1:0]            fwd_sel_rt;
  logic [31:0]           stall_cycles;

  modport master (
    output issue_valid, issue_regwrite, issue_is_load, issue_dst, flush,
    output q_rs, q_rt, q_use_rs, q_use_rt,
    input  stall, fwd_sel_rs, fwd_sel_rt, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_is_load, issue_dst, flush,
    input  q_rs, q_rt, q_use_rs, q_use_rt,
    output stall, fwd_sel_rs, fwd_sel_rt, stall_cycles
  );

endinterface

// File: rtl/scoreboard_entry.sv
// One tracked register: busy flag, pipeline age and producer kind.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   alloc         : a new producer for this register is accepted this cycle
//   alloc_is_load : that producer is a load
//   busy          : a write to this register is still in flight
//   ready         : in flight and the value can already be forwarded
//   fwd           : forwarding stage holding the value (FWD_RF when not ready)
module scoreboard_entry
  import pipe_pkg::*;
#(
  parameter int AGE_W          = 3,
  parameter int ALU_READY_AGE  = DEF_ALU_READY_AGE,
  parameter int LOAD_READY_AGE = DEF_LOAD_READY_AGE,
  parameter int RETIRE_AGE     = DEF_RETIRE_AGE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       alloc,
  input  logic       alloc_is_load,
  output logic       busy,
  output logic       ready,
  output logic [1:0] fwd
);

  localparam logic [AGE_W-1:0] ALU_AGE_C  = AGE_W'(ALU_READY_AGE);
  localparam logic [AGE_W-1:0] LOAD_AGE_C = AGE_W'(LOAD_READY_AGE);
  localparam logic [AGE_W-1:0] RETIRE_C   = AGE_W'(RETIRE_AGE);
  localparam logic [AGE_W-1:0] EX3_C      = AGE_W'(AGE_EX3);
  localparam logic [AGE_W-1:0] MEM_C      = AGE_W'(AGE_MEM);
  localparam logic [AGE_W-1:0] WB_C       = AGE_W'(AGE_WB);

  logic             busy_q;
  logic             load_q;
  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_inc;

  assign age_inc = age_q + AGE_W'(1);

  // A new allocation beats both aging and retirement of the old producer:
  // the newest write is the one decode must wait for.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q <= 1'b0;
      load_q <= 1'b0;
      age_q  <= '0;
    end else if (alloc) begin
      busy_q <= 1'b1;
      load_q <= alloc_is_load;
      age_q  <= '0;
    end else if (busy_q) begin
      if (age_inc == RETIRE_C) begin
        busy_q <= 1'b0;
        load_q <= 1'b0;
        age_q  <= '0;
      end else begin
        age_q <= age_inc;
      end
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q && (load_q ? (age_q >= LOAD_AGE_C) : (age_q >= ALU_AGE_C));

  always_comb begin
    fwd = FWD_RF;
    if (ready) begin
      if (age_q == EX3_C)      fwd = FWD_EX3;
      else if (age_q == MEM_C) fwd = FWD_MEM;
      else if (age_q == WB_C)  fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for decode. Tracks every in-flight register
// write by its age in the EX1->EX2->EX3->MEM->WB chain and answers, for the
// two source operands of the decode instruction, whether decode must stall
// and which downstream stage can forward the value.
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high; drops all in-flight entries
//   sb    : reg_scoreboard_if.slave (issue, flush, query, stall, fwd selects,
//           stall_cycles)
// Optional: define SCOREBOARD_STATS_EN to count cycles in which a valid
// decode instruction was stalled (saturating); otherwise stall_cycles = 0.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int AGE_W          = 3,
  parameter int ALU_READY_AGE  = DEF_ALU_READY_AGE,
  parameter int LOAD_READY_AGE = DEF_LOAD_READY_AGE,
  parameter int RETIRE_AGE     = DEF_RETIRE_AGE
) (
  input logic             Clk,
  input logic             Reset,
  reg_scoreboard_if.slave sb
);

  // Ages must never wrap or an old producer would look freshly issued.
  if (RETIRE_AGE >= (1 << AGE_W)) begin : g_age_check
    $error("RETIRE_AGE must fit in AGE_W bits");
  end

  logic [NUM_REGS-1:0] busy_v;
  logic [NUM_REGS-1:0] ready_v;
  logic [1:0]          fwd_v [NUM_REGS];
  logic                stall_rs;
  logic                stall_rt;
  logic                stall_w;
  logic                accept;

  // Register 0 is hardwired and never produces a hazard.
  assign busy_v[0]  = 1'b0;
  assign ready_v[0] = 1'b0;
  assign fwd_v[0]   = FWD_RF;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    scoreboard_entry #(
      .AGE_W          (AGE_W),
      .ALU_READY_AGE  (ALU_READY_AGE),
      .LOAD_READY_AGE (LOAD_READY_AGE),
      .RETIRE_AGE     (RETIRE_AGE)
    ) u_entry (
      .Clk           (Clk),
      .Reset         (Reset),
      .alloc         (accept && (sb.issue_dst == REG_ADDR_W'(i))),
      .alloc_is_load (sb.issue_is_load),
      .busy          (busy_v[i]),
      .ready         (ready_v[i]),
      .fwd           (fwd_v[i])
    );
  end

  // Queries look only at registered entry state, so the instruction being
  // issued this cycle never hazards against itself.
  assign stall_rs = sb.q_use_rs && busy_v[sb.q_rs] && !ready_v[sb.q_rs];
  assign stall_rt = sb.q_use_rt && busy_v[sb.q_rt] && !ready_v[sb.q_rt];
  assign stall_w  = stall_rs || stall_rt;

  assign sb.stall      = stall_w;
  assign sb.fwd_sel_rs = sb.q_use_rs ? fwd_v[sb.q_rs] : FWD_RF;
  assign sb.fwd_sel_rt = sb.q_use_rt ? fwd_v[sb.q_rt] : FWD_RF;

  assign accept = sb.issue_valid && sb.issue_regwrite && !stall_w && !sb.flush &&
                  (sb.issue_dst != '0);

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (stall_w && sb.issue_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb.stall_cycles = stall_cnt_q;
`else
  assign sb.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios plus random traffic.
// Each driven cycle pushes the reference model's expected outputs into
// exp_q; a negedge monitor pops and compares against the DUT.
module tb_reg_scoreboard;
  import pipe_pkg::*;

  localparam int RETIRE   = 5;
  localparam int ALU_AGE  = 2;
  localparam int LOAD_AGE = 4;
`ifdef SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  reg_scoreboard_if sb_if();

  reg_scoreboard dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sb    (sb_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // A producer is remembered by the cycle in which it sits in EX1 (its
  // "birth"); its stage in any later cycle is just the elapsed cycles.
  bit  live  [32];
  int  born  [32];
  bit  mload [32];
  int  cnt_model = 0;

  logic [36:0] exp_q[$];

  function automatic void src_exp(input logic [4:0] s, input bit u,
                                  output bit st, output logic [1:0] f);
    int age;
    int need;
    st = 1'b0;
    f  = 2'd0;
    if (u && s != 5'd0 && live[s]) begin
      age = cyc - born[s];
      if (age < RETIRE) begin
        need = mload[s] ? LOAD_AGE : ALU_AGE;
        if (age < need) st = 1'b1;
        else f = 2'(age - 1);  // age 2 -> EX3 (1), 3 -> MEM (2), 4 -> WB (3)
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit rw, input bit ld, input logic [4:0] dst,
                       input bit fl, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt);
    bit s_rs, s_rt, est;
    logic [1:0] f_rs, f_rt;
    @(posedge Clk); #1;
    Reset                = 1'b0;
    sb_if.issue_valid    = v;
    sb_if.issue_regwrite = rw;
    sb_if.issue_is_load  = ld;
    sb_if.issue_dst      = dst;
    sb_if.flush          = fl;
    sb_if.q_rs           = rs;
    sb_if.q_rt           = rt;
    sb_if.q_use_rs       = urs;
    sb_if.q_use_rt       = urt;
    src_exp(rs, urs, s_rs, f_rs);
    src_exp(rt, urt, s_rt, f_rt);
    est = s_rs | s_rt;
    exp_q.push_back({(STATS ? 32'(cnt_model) : 32'd0), est, f_rs, f_rt});
    if (v && est) cnt_model++;
    if (v && rw && !est && !fl && dst != 5'd0) begin
      live[dst]  = 1'b1;
      born[dst]  = cyc + 1;
      mload[dst] = ld;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset                = 1'b1;
    sb_if.issue_valid    = 1'b0;
    sb_if.issue_regwrite = 1'b0;
    sb_if.flush          = 1'b0;
    sb_if.q_use_rs       = 1'b0;
    sb_if.q_use_rt       = 1'b0;
    exp_q.push_back({(STATS ? 32'(cnt_model) : 32'd0), 1'b0, 2'd0, 2'd0});
    for (int r = 0; r < 32; r++) live[r] = 1'b0;
    cnt_model = 0;
  endtask

  task automatic q_rs(input logic [4:0] r);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, r, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic q_rt(input logic [4:0] r);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, r, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Directed check against values written straight from the scenario.
  task automatic chk(input string nm, input bit es, input logic [1:0] ers,
                     input logic [1:0] ert, input logic [31:0] ecnt);
    @(negedge Clk);
    total++;
    if (sb_if.stall !== es || sb_if.fwd_sel_rs !== ers || sb_if.fwd_sel_rt !== ert ||
        sb_if.stall_cycles !== ecnt) begin
      bad++;
      $display("FAIL %s: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
               nm, sb_if.stall, sb_if.fwd_sel_rs, sb_if.fwd_sel_rt, sb_if.stall_cycles,
               es, ers, ert, ecnt);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [36:0] e;
    logic [36:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {sb_if.stall_cycles, sb_if.stall, sb_if.fwd_sel_rs, sb_if.fwd_sel_rt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb cyc=%0d: got cnt=%0d stall=%0b rs=%0d rt=%0d, want cnt=%0d stall=%0b rs=%0d rt=%0d",
                 cyc, a[36:5], a[4], a[3:2], a[1:0], e[36:5], e[4], e[3:2], e[1:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < 32; r++) begin
      live[r] = 1'b0; born[r] = 0; mload[r] = 1'b0;
    end
    sb_if.issue_valid    = 1'b0;
    sb_if.issue_regwrite = 1'b0;
    sb_if.issue_is_load  = 1'b0;
    sb_if.issue_dst      = 5'd0;
    sb_if.flush          = 1'b0;
    sb_if.q_rs           = 5'd0;
    sb_if.q_rt           = 5'd0;
    sb_if.q_use_rs       = 1'b0;
    sb_if.q_use_rt       = 1'b0;
    repeat (3) @(posedge Clk);

    // 1: idle after reset
    q_rs(5'd8);
    chk("reset_q8", 1'b0, FWD_RF, FWD_RF, 32'd0);

    // 2: ALU producer to $8, consumer from the next cycle
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    q_rs(5'd8); chk("alu_c1", 1'b1, FWD_RF,  FWD_RF, 32'd0);
    q_rs(5'd8); chk("alu_c2", 1'b1, FWD_RF,  FWD_RF, STATS ? 32'd1 : 32'd0);
    q_rs(5'd8); chk("alu_c3", 1'b0, FWD_EX3, FWD_RF, STATS ? 32'd2 : 32'd0);
    q_rs(5'd8); chk("alu_c4", 1'b0, FWD_MEM, FWD_RF, STATS ? 32'd2 : 32'd0);
    q_rs(5'd8); chk("alu_c5", 1'b0, FWD_WB,  FWD_RF, STATS ? 32'd2 : 32'd0);
    q_rs(5'd8); chk("alu_c6", 1'b0, FWD_RF,  FWD_RF, STATS ? 32'd2 : 32'd0);

    // 3: load producer to $9, consumer on rt
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      q_rt(5'd9);
      chk("load_stall", 1'b1, FWD_RF, FWD_RF, STATS ? 32'(k - 1) : 32'd0);
    end
    q_rt(5'd9); chk("load_c5", 1'b0, FWD_RF, FWD_WB, STATS ? 32'd4 : 32'd0);

    // 4: WAW on $10, newest (ALU) producer wins; rs==rt identical selects
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle();
    q_rs(5'd10); chk("waw_c3", 1'b1, FWD_RF, FWD_RF, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd10, 1'b1, 1'b1);
    chk("waw_c4", 1'b0, FWD_EX3, FWD_EX3, STATS ? 32'd1 : 32'd0);

    // 5: flushed issue and writes to $0 never allocate
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    q_rs(5'd11); chk("flush_q11", 1'b0, FWD_RF, FWD_RF, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("r0_q", 1'b0, FWD_RF, FWD_RF, 32'd0);

    // 6: reset in the middle of a load hazard
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    q_rt(5'd9); chk("rst_c1", 1'b1, FWD_RF, FWD_RF, 32'd0);
    do_reset();
    q_rt(5'd9); chk("rst_c3", 1'b0, FWD_RF, FWD_RF, 32'd0);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
    end
    idle();

    @(negedge Clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
